// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: assembles byte-serial ALU command frames, issues one op, streams result/status bytes
module alu_cmd_sequencer #(
  parameter int         A_WIDTH    = 16,
  parameter int         TIMEOUT    = 15,
  parameter logic [3:0] HDR_NIBBLE = 4'hC
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         RX_DATA,
  input  logic               RX_VALID,
  output logic [A_WIDTH-1:0] ALU_A,
  output logic [A_WIDTH-1:0] ALU_B,
  output logic [3:0]         ALU_FUN,
  output logic               ALU_EN,
  input  logic [A_WIDTH-1:0] ALU_OUT,
  input  logic               ALU_CARRY,
  input  logic               ALU_OUT_VALID,
  output logic [7:0]         TX_DATA,
  output logic               TX_VALID,
  input  logic               TX_READY,
  output logic               BUSY,
  output logic               ERR_HDR,
  output logic               ERR_OVR,
  output logic               ERR_TMO
);
  localparam int NB = A_WIDTH / 8;
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, ISSUE, WAIT, SEND_RES, SEND_STAT, SEND_ERR} state_t;
  state_t state, state_n;
  logic [1:0] cnt;
  logic [7:0] tcnt;
  logic [A_WIDTH-1:0] res;
  logic carry, last, hdr_ok, tmo;
  assign last   = cnt == 2'(NB - 1);
  assign hdr_ok = RX_DATA[7:4] == HDR_NIBBLE;
  assign tmo    = state == WAIT && !ALU_OUT_VALID && tcnt == 8'(TIMEOUT - 1);
  // state register
  always_ff @(posedge CLK)
    state <= RST ? IDLE : state_n;
  // next-state and handshake outputs; TX bytes come straight from the state so reset drops them at once
  always_comb begin
    state_n  = state;
    ALU_EN   = 1'b0;
    TX_VALID = 1'b0;
    TX_DATA  = 8'h00;
    BUSY     = state != IDLE;
    case (state)
      IDLE:      state_n = RX_VALID && hdr_ok ? GET_A : IDLE;
      GET_A:     state_n = RX_VALID && last ? GET_B : GET_A;
      GET_B:     state_n = RX_VALID && last ? ISSUE : GET_B;
      ISSUE: begin
        ALU_EN  = 1'b1;
        state_n = WAIT;
      end
      WAIT:      state_n = ALU_OUT_VALID ? SEND_RES : tmo ? SEND_ERR : WAIT;
      SEND_RES: begin
        TX_VALID = 1'b1;
        TX_DATA  = res[7:0];
        state_n  = TX_READY && last ? SEND_STAT : SEND_RES;
      end
      SEND_STAT: begin
        TX_VALID = 1'b1;
        TX_DATA  = {7'b0, carry};
        state_n  = TX_READY ? IDLE : SEND_STAT;
      end
      SEND_ERR: begin
        TX_VALID = 1'b1;
        TX_DATA  = 8'hEE;
        state_n  = TX_READY ? IDLE : SEND_ERR;
      end
      default:   state_n = IDLE;
    endcase
  end
  // datapath: operands shift in LSB first, result shifts out LSB first, error strobes registered
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= 2'd0;
      tcnt    <= 8'd0;
      ALU_A   <= '0;
      ALU_B   <= '0;
      ALU_FUN <= 4'h0;
      res     <= '0;
      carry   <= 1'b0;
      ERR_HDR <= 1'b0;
      ERR_OVR <= 1'b0;
      ERR_TMO <= 1'b0;
    end else begin
      ERR_HDR <= state == IDLE && RX_VALID && !hdr_ok;
      ERR_OVR <= RX_VALID && state inside {ISSUE, WAIT, SEND_RES, SEND_STAT, SEND_ERR};
      ERR_TMO <= tmo;
      tcnt    <= state == WAIT ? tcnt + 8'd1 : 8'd0;
      if (state == IDLE && RX_VALID && hdr_ok) ALU_FUN <= RX_DATA[3:0];
      if (state == GET_A && RX_VALID) ALU_A <= A_WIDTH'({RX_DATA, ALU_A} >> 8);
      if (state == GET_B && RX_VALID) ALU_B <= A_WIDTH'({RX_DATA, ALU_B} >> 8);
      if (((state == GET_A || state == GET_B) && RX_VALID) || (state == SEND_RES && TX_READY))
        cnt <= last ? 2'd0 : cnt + 2'd1;
      if (state == WAIT && ALU_OUT_VALID) begin
        res   <= ALU_OUT;
        carry <= ALU_CARRY;
      end else if (state == SEND_RES && TX_READY)
        res <= res >> 8;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed and randomized frames against a queue-based reference of the TX stream
module tb_alu_cmd_sequencer;
  localparam int W = 16, NB = 2, TMO = 15;
  logic CLK = 0, RST = 1;
  logic [7:0] RX_DATA = 0;
  logic RX_VALID = 0;
  logic [W-1:0] ALU_A, ALU_B, ALU_OUT = 0;
  logic [3:0] ALU_FUN;
  logic ALU_EN, ALU_CARRY = 0, ALU_OUT_VALID = 0;
  logic [7:0] TX_DATA;
  logic TX_VALID, TX_READY = 1, BUSY, ERR_HDR, ERR_OVR, ERR_TMO;
  int checks = 0, errors = 0;

  alu_cmd_sequencer #(.A_WIDTH(W), .TIMEOUT(TMO), .HDR_NIBBLE(4'hC)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_CARRY(ALU_CARRY), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .BUSY(BUSY), .ERR_HDR(ERR_HDR), .ERR_OVR(ERR_OVR), .ERR_TMO(ERR_TMO));

  always #5 CLK = ~CLK;

  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    return f < 4'd2 ? {1'b0, a} + {1'b0, b} : f == 4'd2 ? {1'b0, a} - {1'b0, b} : {1'b0, a ^ b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  int lat = 1, cd = 0;
  bit never = 0;
  always @(posedge CLK) begin
    if (RST) begin
      cd <= 0;
      ALU_OUT_VALID <= 0;
    end else if (ALU_EN && !never) begin
      cd <= lat - 1;
      ALU_OUT_VALID <= lat == 1;
      {ALU_CARRY, ALU_OUT} <= alu_f(ALU_A, ALU_B, ALU_FUN);
    end else begin
      ALU_OUT_VALID <= cd == 1;
      cd <= cd > 0 ? cd - 1 : 0;
    end
  end

  int ncyc = 0, en_cnt = 0, en_cyc = 0, hdr_cnt = 0, ovr_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, rx_last = 0, tx_first = 0;
  logic [W-1:0] en_a, en_b;
  logic [3:0] en_fun;
  logic [7:0] got[$], expq[$];
  logic pv = 0, pr = 0, prst = 0;
  logic [7:0] pd = 0;
  always @(negedge CLK) begin
    ncyc++;
    if (RX_VALID) rx_last = ncyc;
    if (ALU_EN === 1'b1) begin
      en_cnt++;
      en_cyc = ncyc;
      en_a = ALU_A;
      en_b = ALU_B;
      en_fun = ALU_FUN;
    end
    if (ERR_HDR === 1'b1) hdr_cnt++;
    if (ERR_OVR === 1'b1) ovr_cnt++;
    if (ERR_TMO === 1'b1) begin
      tmo_cnt++;
      tmo_cyc = ncyc;
    end
    if (TX_VALID === 1'b1 && !pv) tx_first = ncyc;
    if (pv && !pr && !prst) begin
      chk("tx_hold_valid", TX_VALID, 1);
      chk("tx_hold_data", TX_DATA, pd);
    end
    if (TX_VALID === 1'b1 && TX_READY && !RST) got.push_back(TX_DATA);
    pv = TX_VALID === 1'b1;
    pr = TX_READY;
    pd = TX_DATA;
    prst = RST;
  end

  int rdy_mode = 0, hold = 0;
  task automatic tick();
    @(posedge CLK);
    #1;
    if (rdy_mode == 0) TX_READY = 1;
    else if (rdy_mode == 1) TX_READY = 1'($urandom_range(0, 1));
    else if (!TX_VALID) begin
      TX_READY = 0;
      hold = 0;
    end else if (hold < 3) begin
      TX_READY = 0;
      hold++;
    end else begin
      TX_READY = 1;
      hold = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VALID = 1;
    tick();
    RX_VALID = 0;
    RX_DATA = 8'($urandom);
  endtask

  task automatic send_frame(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b);
    send_byte({4'hC, fun});
    for (int i = 0; i < NB; i++) send_byte(8'(a >> (8 * i)));
    for (int i = 0; i < NB; i++) send_byte(8'(b >> (8 * i)));
  endtask

  task automatic exp_push(input logic [3:0] fun, input logic [W-1:0] a, input logic [W-1:0] b, input bit nv);
    logic [W:0] r;
    r = alu_f(a, b, fun);
    if (nv) expq.push_back(8'hEE);
    else begin
      for (int i = 0; i < NB; i++) expq.push_back(8'(r >> (8 * i)));
      expq.push_back({7'b0, r[W]});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 300) begin
      tick();
      n++;
    end
    chk(tag, BUSY, 0);
  endtask

  task automatic cmp_tx(input string tag);
    chk({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) chk({tag, "_byte"}, got[i], expq[i]);
  endtask

  task automatic run_frame(input string tag, input logic [3:0] fun, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int l, input bit nv);
    int e0, t0, lb;
    e0 = en_cnt;
    t0 = tmo_cnt;
    got.delete();
    expq.delete();
    lat = l;
    never = nv;
    exp_push(fun, a, b, nv);
    send_frame(fun, a, b);
    lb = rx_last;
    wait_idle({tag, "_idle"});
    chk({tag, "_en_pulses"}, en_cnt - e0, 1);
    chk({tag, "_en_latency"}, en_cyc, lb + 1);
    chk({tag, "_alu_a"}, en_a, a);
    chk({tag, "_alu_b"}, en_b, b);
    chk({tag, "_alu_fun"}, en_fun, fun);
    chk({tag, "_tmo_pulses"}, tmo_cnt - t0, nv ? 1 : 0);
    if (nv) chk({tag, "_tmo_cycle"}, tmo_cyc, en_cyc + 1 + TMO);
    chk({tag, "_tx_latency"}, tx_first, nv ? en_cyc + 1 + TMO : en_cyc + l + 1);
    cmp_tx(tag);
    chk({tag, "_a_held"}, ALU_A, a);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_alu_a"}, ALU_A, 0);
    chk({tag, "_alu_b"}, ALU_B, 0);
    chk({tag, "_alu_fun"}, ALU_FUN, 0);
    chk({tag, "_alu_en"}, ALU_EN, 0);
    chk({tag, "_tx"}, {TX_DATA, TX_VALID}, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_err"}, {ERR_HDR, ERR_OVR, ERR_TMO}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, o0, n;
    logic [3:0] nib;
    RST = 1;
    tick();
    tick();
    chk_reset_outs("reset");
    RST = 0;
    tick();
    run_frame("p1", 4'h0, 16'h1234, 16'h0001, 1, 0);
    chk("p1_bytes", {got[0], got[1], got[2]}, 24'h351200);
    rdy_mode = 2;
    run_frame("p2", 4'h1, 16'hFFFF, 16'h0001, 1, 0);
    chk("p2_bytes", {got[0], got[1], got[2]}, 24'h000001);
    rdy_mode = 0;
    h0 = hdr_cnt;
    send_byte(8'h5A);
    chk("hdr_pulse_now", ERR_HDR, 1);
    tick();
    chk("hdr_pulses", hdr_cnt - h0, 1);
    chk("hdr_busy", BUSY, 0);
    run_frame("p3", 4'h2, 16'h0102, 16'h0201, 1, 0);
    run_frame("p4_tmo", 4'h3, 16'hBEEF, 16'h1111, 1, 1);
    run_frame("lat15", 4'h0, 16'h8000, 16'h8000, 15, 0);
    run_frame("lat14", 4'h5, 16'hA5A5, 16'h5A5A, 14, 0);
    // overrun strobes during ISSUE/WAIT and during a stalled SEND_RES
    rdy_mode = 2;
    got.delete();
    expq.delete();
    lat = 4;
    never = 0;
    o0 = ovr_cnt;
    exp_push(4'h0, 16'h4321, 16'h1111, 0);
    send_frame(4'h0, 16'h4321, 16'h1111);
    for (int i = 0; i < 3; i++) send_byte(8'hC3);
    n = 0;
    while (!TX_VALID && n < 50) begin
      tick();
      n++;
    end
    chk("ovr_tx_seen", TX_VALID, 1);
    send_byte(8'hC7);
    send_byte(8'h12);
    wait_idle("ovr_idle");
    tick();
    chk("ovr_pulses", ovr_cnt - o0, 5);
    cmp_tx("ovr");
    rdy_mode = 0;
    run_frame("after_ovr", 4'h4, 16'h0F0F, 16'hF00F, 1, 0);
    // reset in GET_B
    got.delete();
    send_byte(8'hC5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    RST = 1;
    tick();
    chk_reset_outs("rst_getb");
    RST = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_getb_no_tx", got.size(), 0);
    run_frame("after_rst1", 4'h1, 16'h7FFF, 16'h0001, 1, 0);
    // reset in SEND_RES after one byte transferred
    rdy_mode = 2;
    got.delete();
    lat = 1;
    send_frame(4'h0, 16'h00FF, 16'h0001);
    n = 0;
    while (got.size() < 1 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_send_one", got.size(), 1);
    RST = 1;
    tick();
    chk_reset_outs("rst_send");
    RST = 0;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_send_no_more", got.size(), 1);
    run_frame("after_rst2", 4'h2, 16'h0003, 16'h0005, 1, 0);
    // randomized frames
    for (int k = 0; k < 25; k++) begin
      rdy_mode = $urandom_range(0, 1);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) tick();
      if ($urandom_range(0, 3) == 0) begin
        nib = 4'($urandom_range(0, 14));
        if (nib >= 4'hC) nib = nib + 4'd1;
        h0 = hdr_cnt;
        send_byte({nib, 4'($urandom)});
        tick();
        chk("rand_hdr", hdr_cnt - h0, 1);
      end
      run_frame("rand", 4'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 15), $urandom_range(0, 5) == 0);
    end
    rdy_mode = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the ALU operation interface. It receives a byte-serial command frame from the receive path and assembles operands A/B and the 4-bit function code. It issues one ALU operation, waits for the registered ALU result, and streams the result and a status byte back to the transmit path through a valid/ready handshake. It sits between the RX byte stream and the ALU block in the system controller.

Parameters:
A_WIDTH, 16, operand/result width in bits; must be a multiple of 8 and between 8 and 32.
TIMEOUT, 15, maximum cycles to wait for ALU_OUT_VALID after issue; must be between 1 and 255.
HDR_NIBBLE, 4'hC, required upper nibble of the command byte.

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
RX_DATA  input  8  received byte
RX_VALID  input  1  one-cycle strobe, RX_DATA valid; no backpressure
ALU_A  output  A_WIDTH  operand A to ALU
ALU_B  output  A_WIDTH  operand B to ALU
ALU_FUN  output  4  function code to ALU
ALU_EN  output  1  one-cycle issue pulse
ALU_OUT  input  A_WIDTH  ALU result
ALU_CARRY  input  1  ALU carry out
ALU_OUT_VALID  input  1  result valid strobe
TX_DATA  output  8  byte to transmitter
TX_VALID  output  1  TX_DATA valid
TX_READY  input  1  transmitter accepts byte
BUSY  output  1  high in any state except IDLE
ERR_HDR  output  1  one-cycle pulse: bad header byte dropped
ERR_OVR  output  1  one-cycle pulse: RX byte dropped while not accepting
ERR_TMO  output  1  one-cycle pulse: ALU timeout

Behaviour:
- NB = A_WIDTH/8. The frame is CMD, then A (NB bytes, LSB first), then B (NB bytes, LSB first). CMD = {HDR_NIBBLE, fun[3:0]}.
- RST is sampled on the CLK rising edge. It forces state IDLE and clears the byte counter and the timeout counter. It sets ALU_A, ALU_B, ALU_FUN, TX_DATA to 0 and ALU_EN, TX_VALID, BUSY and all ERR_* to 0. Reset mid-frame or mid-send abandons the frame with no further TX bytes.
- States: IDLE, GET_A, GET_B, ISSUE, WAIT, SEND_RES, SEND_STAT, SEND_ERR.
- IDLE: on RX_VALID with RX_DATA[7:4]==HDR_NIBBLE, latch ALU_FUN=RX_DATA[3:0] and go to GET_A. On RX_VALID with a bad nibble, pulse ERR_HDR the next cycle and stay in IDLE.
- GET_A / GET_B: each RX_VALID loads byte k of the operand, where the byte counter is 0..NB-1. After the last byte the counter wraps to 0 and the FSM advances (GET_A to GET_B, GET_B to ISSUE). There is no inter-byte timeout.
- ISSUE: ALU_EN=1 for exactly one cycle, then WAIT. ALU_A, ALU_B and ALU_FUN are held stable from ISSUE until the FSM returns to IDLE.
- WAIT: the timeout counter starts at 0 on entry and increments each cycle. ALU_OUT_VALID is sampled from the first WAIT cycle.
  - On valid: capture ALU_OUT and ALU_CARRY, go to SEND_RES.
  - If the counter reaches TIMEOUT with no valid: pulse ERR_TMO and go to SEND_ERR.
  - Valid and timeout in the same cycle: valid wins.
- SEND_RES: present captured result bytes LSB first, NB bytes, then go to SEND_STAT. SEND_STAT sends the byte {7'b0, carry}, then IDLE. SEND_ERR sends the single byte 8'hEE, then IDLE.
- TX handshake:
  - TX_VALID stays high and TX_DATA stays stable until a cycle with TX_VALID&TX_READY; that cycle is the transfer.
  - The next byte appears the following cycle, so at most one byte transfers per cycle.
  - TX_VALID is never deasserted without a transfer except by RST.
- RX_VALID in ISSUE, WAIT, SEND_RES, SEND_STAT or SEND_ERR: the byte is discarded and ERR_OVR pulses the next cycle; there is no other effect.
- In the last SEND cycle the FSM returns to IDLE. A new CMD is accepted on the first IDLE cycle.
- Frame-to-TX latency with TX_READY tied high and ALU valid one cycle after ALU_EN:
  - ALU_EN rises 1 cycle after the last B byte.
  - The first TX_VALID appears 2 cycles after ALU_EN.

Test Plan:
- A_WIDTH=16, RX C0 34 12 01 00; ALU model returns 0x1235, carry 0, one cycle after ALU_EN -> ALU_A=0x1234, ALU_B=0x0001, ALU_FUN=0, single ALU_EN pulse; TX bytes 35 12 00; BUSY low afterwards.
- RX C1 FF FF 01 00; model returns 0x0000, carry 1; TX_READY low for 3 cycles on each byte -> TX_DATA held stable while stalled, bytes 00 00 01 each transferred exactly once.
- RX 5A, then C2 ... -> ERR_HDR pulse after 5A; the following frame is processed normally with ALU_FUN=2.
- Valid frame with ALU_OUT_VALID never asserted -> ERR_TMO pulses exactly TIMEOUT=15 cycles after the WAIT entry; TX byte EE only; return to IDLE.
- RX_VALID strobes during WAIT and SEND_RES -> ERR_OVR pulse per byte; result unchanged; the next frame accepted after return to IDLE.
- RST asserted in GET_B and again in SEND_RES (after 1 byte sent) -> next edge: all outputs 0, IDLE, no further TX bytes; a fresh frame then completes correctly.
